// File: rtl/psum_deskew_collector_pkg.sv
// Shared parameters and FSM state encoding for the partial-sum de-skew collector.
package psum_deskew_collector_pkg;

    localparam int unsigned DEF_ARRAY_SIZE = 8;
    localparam int unsigned DEF_PSUM_WIDTH = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/psum_deskew_collector.sv
// Captures the diagonally skewed partial-sum lanes of the PE array into a tile buffer
// and streams complete result rows out with a valid/ready handshake.
module psum_deskew_collector
    import psum_deskew_collector_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int unsigned PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int unsigned IDX_WIDTH  = $clog2(ARRAY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ARRAY_SIZE*PSUM_WIDTH-1:0] psum_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ARRAY_SIZE*PSUM_WIDTH-1:0] out_row,
    output logic [IDX_WIDTH-1:0]             out_row_idx,
    output logic                             busy,
    output logic                             done,
    output logic                             start_err
);

    localparam int unsigned          CNT_W    = $clog2(2 * ARRAY_SIZE) + 1;
    localparam logic [CNT_W-1:0]     LAST_C   = CNT_W'(2 * ARRAY_SIZE - 2);
    localparam logic [CNT_W-1:0]     N_C      = CNT_W'(ARRAY_SIZE);
    localparam logic [IDX_WIDTH-1:0] LAST_ROW = IDX_WIDTH'(ARRAY_SIZE - 1);

    state_e                          r_state;
    state_e                          w_state_nxt;
    logic [CNT_W-1:0]                r_cap_cnt;
    logic [CNT_W-1:0]                w_cap_cnt_nxt;
    logic [CNT_W-1:0]                w_c;
    logic                            w_cap_active;
    logic [IDX_WIDTH-1:0]            r_rd_row;
    logic [IDX_WIDTH-1:0]            w_rd_nxt;
    logic                            w_xfer;
    logic                            w_last_xfer;
    logic                            w_valid_nxt;
    logic                            r_out_valid;
    logic [ARRAY_SIZE*PSUM_WIDTH-1:0] r_out_row;
    logic [IDX_WIDTH-1:0]            r_out_idx;
    logic                            r_busy;
    logic                            r_start_err;
    logic [ARRAY_SIZE-1:0]           w_we;
    logic [IDX_WIDTH-1:0]            w_col  [ARRAY_SIZE];
    logic [PSUM_WIDTH-1:0]           w_lane [ARRAY_SIZE];
    logic [PSUM_WIDTH-1:0]           r_buf  [ARRAY_SIZE][ARRAY_SIZE];
    logic [ARRAY_SIZE*PSUM_WIDTH-1:0] w_row_fwd;

    assign w_xfer       = r_out_valid & out_ready;
    assign w_last_xfer  = w_xfer & (r_rd_row == LAST_ROW);
    assign w_cap_active = (r_state == ST_CAPTURE) | ((r_state == ST_IDLE) & start);
    // The start cycle itself is capture cycle 0, before the counter has moved.
    assign w_c          = (r_state == ST_CAPTURE) ? r_cap_cnt : {CNT_W{1'b0}};

    genvar gi, gj;
    generate
        for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            localparam logic [CNT_W-1:0] LANE = CNT_W'(gi);
            logic [CNT_W-1:0] w_diff;

            // c - i wraps to a large value when c < i, so one compare covers both bounds.
            assign w_lane[gi] = psum_in[gi*PSUM_WIDTH +: PSUM_WIDTH];
            assign w_diff     = w_c - LANE;
            assign w_we[gi]   = w_cap_active & (w_diff < N_C);
            assign w_col[gi]  = w_diff[IDX_WIDTH-1:0];

            for (gj = 0; gj < ARRAY_SIZE; gj++) begin : g_col
                localparam logic [IDX_WIDTH-1:0] COL = IDX_WIDTH'(gj);

                // Tile buffer cell write; contents are don't-care after reset.
                always_ff @(posedge clk) begin
                    if (w_we[gi] && (w_col[gi] == COL)) begin
                        r_buf[gi][gj] <= w_lane[gi];
                    end else begin
                        r_buf[gi][gj] <= r_buf[gi][gj];
                    end
                end
            end
        end
    endgenerate

    // Next-state and capture counter sequencing.
    always_comb begin
        w_state_nxt   = r_state;
        w_cap_cnt_nxt = r_cap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_CAPTURE;
                    w_cap_cnt_nxt = CNT_W'(1);
                end else begin
                    w_cap_cnt_nxt = {CNT_W{1'b0}};
                end
            end
            ST_CAPTURE: begin
                w_cap_cnt_nxt = r_cap_cnt + CNT_W'(1);
                if (r_cap_cnt == LAST_C) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (w_last_xfer) begin
                    w_state_nxt   = ST_IDLE;
                    w_cap_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_cap_cnt_nxt = {CNT_W{1'b0}};
            end
        endcase
    end

    // Read pointer advance and next-cycle row availability.
    always_comb begin
        w_rd_nxt = r_rd_row;
        if (w_last_xfer) begin
            w_rd_nxt = {IDX_WIDTH{1'b0}};
        end else if (w_xfer) begin
            w_rd_nxt = r_rd_row + IDX_WIDTH'(1);
        end else begin
            w_rd_nxt = r_rd_row;
        end
        w_valid_nxt = (w_state_nxt != ST_IDLE) &&
                      (w_cap_cnt_nxt >= (CNT_W'(w_rd_nxt) + N_C));
    end

    // A row's final element lands at the same edge the row register loads, so forward it.
    always_comb begin
        w_row_fwd = {(ARRAY_SIZE*PSUM_WIDTH){1'b0}};
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            if (w_we[w_rd_nxt] && (w_col[w_rd_nxt] == IDX_WIDTH'(j))) begin
                w_row_fwd[j*PSUM_WIDTH +: PSUM_WIDTH] = w_lane[w_rd_nxt];
            end else begin
                w_row_fwd[j*PSUM_WIDTH +: PSUM_WIDTH] = r_buf[w_rd_nxt][j];
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cap_cnt   <= {CNT_W{1'b0}};
            r_rd_row    <= {IDX_WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_out_row   <= {(ARRAY_SIZE*PSUM_WIDTH){1'b0}};
            r_out_idx   <= {IDX_WIDTH{1'b0}};
            r_busy      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cap_cnt   <= w_cap_cnt_nxt;
            r_rd_row    <= w_rd_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_start_err <= start & (r_state != ST_IDLE);
            if (r_out_valid && !out_ready) begin
                r_out_valid <= r_out_valid;
                r_out_row   <= r_out_row;
                r_out_idx   <= r_out_idx;
            end else if (w_valid_nxt) begin
                r_out_valid <= 1'b1;
                r_out_row   <= w_row_fwd;
                r_out_idx   <= w_rd_nxt;
            end else begin
                r_out_valid <= 1'b0;
                r_out_row   <= r_out_row;
                r_out_idx   <= r_out_idx;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_row     = r_out_row;
    assign out_row_idx = r_out_idx;
    assign busy        = r_busy;
    assign start_err   = r_start_err;
    assign done        = w_last_xfer & ~rst;

endmodule
